// File: rtl/i2c_slave_single.sv
// I2C target: synchronises SCL/SDA, matches ADDRESS, ACKs writes, serves reads
// from tx_data and stretches SCL until a read byte is supplied and settled.
module i2c_slave_single #(
  parameter logic [6:0] ADDRESS      = 7'h50,
  parameter int         SYNC_DEPTH   = 3,
  parameter int         SETUP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       stop_det,
  output logic       m_nack
);

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD_LOAD, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  state_t                r_state;
  logic [SYNC_DEPTH-1:0] r_scl_sync;
  logic [SYNC_DEPTH-1:0] r_sda_sync;
  logic                  r_scl_prev;
  logic                  r_sda_prev;
  logic                  r_scl_low;
  logic                  r_sda_low;
  logic                  r_sda_low_q;
  logic [SYNC_DEPTH:0]   r_drv_hist;
  logic                  r_fall_d;
  logic [3:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_ack_on;
  logic                  r_first;
  logic                  r_rw;
  logic                  r_loaded;
  logic [SCW-1:0]        r_setup_cnt;
  logic [7:0]            r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_first;
  logic                  r_tx_ready;
  logic                  r_busy;
  logic                  r_stop_det;
  logic                  r_m_nack;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda_mask;
  logic w_start;
  logic w_stop;

  assign scl = r_scl_low ? 1'b0 : 1'bz;
  assign sda = r_sda_low ? 1'b0 : 1'bz;

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_first = r_rx_first;
  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;
  assign stop_det = r_stop_det;
  assign m_nack   = r_m_nack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync[0] <= scl;
      r_sda_sync[0] <= sda;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_DEPTH-1];
  assign w_sda      = r_sda_sync[SYNC_DEPTH-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;

  // Our own SDA transitions reach the synced value SYNC_DEPTH clks later; keep
  // a short history of drive changes so they never look like START/STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sda_low_q <= 1'b0;
      r_drv_hist  <= '0;
    end else begin
      r_sda_low_q <= r_sda_low;
      r_drv_hist  <= {r_drv_hist[SYNC_DEPTH-1:0], r_sda_low ^ r_sda_low_q};
    end
  end

  assign w_sda_mask = (|r_drv_hist) | (r_sda_low ^ r_sda_low_q);
  assign w_start    = w_scl & r_scl_prev & ~w_sda & r_sda_prev & ~w_sda_mask;
  assign w_stop     = w_scl & r_scl_prev & w_sda & ~r_sda_prev & ~w_sda_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_scl_low   <= 1'b0;
      r_sda_low   <= 1'b0;
      r_fall_d    <= 1'b0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_ack_on    <= 1'b0;
      r_first     <= 1'b0;
      r_rw        <= 1'b0;
      r_loaded    <= 1'b0;
      r_setup_cnt <= '0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_stop_det  <= 1'b0;
      r_m_nack    <= 1'b0;
    end else begin
      r_fall_d   <= w_scl_fall;
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_tx_ready <= 1'b0;
      r_stop_det <= 1'b0;
      r_m_nack   <= 1'b0;
      if (w_stop) begin
        r_state    <= S_IDLE;
        r_scl_low  <= 1'b0;
        r_sda_low  <= 1'b0;
        r_stop_det <= 1'b1;
        r_busy     <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_ack_on  <= 1'b0;
        r_scl_low <= 1'b0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                if (r_shift[6:0] == ADDRESS) begin
                  r_state  <= S_ADDR_ACK;
                  r_busy   <= 1'b1;
                  r_ack_on <= 1'b0;
                  r_rw     <= w_sda;
                end else begin
                  r_state <= S_IGNORE;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          // ACK is driven for exactly one SCL low-high-low window
          S_ADDR_ACK, S_WR_ACK: begin
            if (r_fall_d) begin
              if (!r_ack_on) begin
                r_sda_low <= 1'b1;
                r_ack_on  <= 1'b1;
              end else begin
                r_sda_low <= 1'b0;
                r_ack_on  <= 1'b0;
                r_bit_cnt <= 4'd0;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  r_state     <= S_RD_LOAD;
                  r_scl_low   <= 1'b1;
                  r_loaded    <= 1'b0;
                  r_setup_cnt <= '0;
                end else begin
                  r_state <= S_WR;
                  if (r_state == S_ADDR_ACK) r_first <= 1'b1;
                end
              end
            end
          end
          S_WR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_rx_data  <= {r_shift[6:0], w_sda};
                r_rx_valid <= 1'b1;
                r_rx_first <= r_first;
                r_first    <= 1'b0;
                r_state    <= S_WR_ACK;
                r_ack_on   <= 1'b0;
              end
            end
          end
          // SCL is held low here; the MSB settles for SETUP_CYCLES before release
          S_RD_LOAD: begin
            if (!r_loaded) begin
              if (tx_valid) begin
                r_shift     <= tx_data;
                r_tx_ready  <= 1'b1;
                r_sda_low   <= ~tx_data[7];
                r_loaded    <= 1'b1;
                r_setup_cnt <= '0;
              end
            end else if (r_setup_cnt == SCW'(SETUP_CYCLES - 1)) begin
              r_scl_low <= 1'b0;
              r_state   <= S_RD;
              r_bit_cnt <= 4'd1;
            end else begin
              r_setup_cnt <= r_setup_cnt + 1'b1;
            end
          end
          S_RD: begin
            if (r_fall_d) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_low <= 1'b0;
                r_state   <= S_RD_ACK;
                r_ack_on  <= 1'b0;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_low <= ~r_shift[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_ack_on <= 1'b1;
              end else begin
                r_m_nack  <= 1'b1;
                r_sda_low <= 1'b0;
                r_state   <= S_IGNORE;
              end
            end else if (r_fall_d && r_ack_on) begin
              r_state     <= S_RD_LOAD;
              r_scl_low   <= 1'b1;
              r_loaded    <= 1'b0;
              r_setup_cnt <= '0;
              r_ack_on    <= 1'b0;
            end
          end
          S_IDLE, S_IGNORE: begin
            r_scl_low <= 1'b0;
            r_sda_low <= 1'b0;
          end
          default: begin
            r_state   <= S_IDLE;
            r_scl_low <= 1'b0;
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
